sixteen_bit_serial_borrow_select_subtractor: RTL and testbench

- Multi-cycle 16-bit subtractor: computes D = A - B - Bin.
- Processes one SLICE-bit slice per clock, least-significant slice first.
- Each slice computes both borrow-in=0 and borrow-in=1 differences, then selects one using the registered borrow.
- Serves as the subtraction counterpart to the team's 16-bit carry-select adder. It sits behind a valid/ready handshake so ALU sequencing logic can issue operations and accept results.

---
 rtl/sixteen_bit_serial_borrow_select_subtractor.sv | 89 ++++++++
 tb/tb_sixteen_bit_serial_borrow_select_subtractor.sv | 119 +++++++++++
 2 files changed

// File: rtl/sixteen_bit_serial_borrow_select_subtractor.sv
// sixteen_bit_serial_borrow_select_subtractor: slice-serial D = A - B - Bin with borrow-select slices
module sixteen_bit_serial_borrow_select_subtractor #(
  parameter int SLICE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] D,
  output logic        Bout,
  output logic        V
);
  localparam int N  = 16 / SLICE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic borrow_q, borrow_d, bout_q, bout_d, v_q, v_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SLICE:0] diff0, diff1, sel;
  logic last;
  always_comb begin
    diff0 = {1'b0, a_q[idx_q*SLICE +: SLICE]} - {1'b0, b_q[idx_q*SLICE +: SLICE]};
    diff1 = diff0 - (SLICE+1)'(1);
    sel = borrow_q ? diff1 : diff0;
    last = idx_q == IW'(N-1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    d_d = d_q;
    borrow_d = borrow_q;
    bout_d = bout_q;
    v_d = v_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = A;
        b_d = B;
        borrow_d = Bin;
        idx_d = '0;
        d_d = '0;
        state_d = RUN;
      end
      RUN: begin
        d_d[idx_q*SLICE +: SLICE] = sel[SLICE-1:0];
        borrow_d = sel[SLICE];
        idx_d = idx_q + IW'(1);
        if (last) begin
          bout_d = sel[SLICE];
          v_d = (a_q[15] ^ b_q[15]) & (sel[SLICE-1] ^ a_q[15]);
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
      borrow_q <= 1'b0;
      bout_q <= 1'b0;
      v_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      d_q <= d_d;
      borrow_q <= borrow_d;
      bout_q <= bout_d;
      v_q <= v_d;
      idx_q <= idx_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign D = d_q;
  assign Bout = bout_q;
  assign V = v_q;
endmodule

// File: tb/tb_sixteen_bit_serial_borrow_select_subtractor.sv
// tb_sixteen_bit_serial_borrow_select_subtractor: directed table, corner sequences and random ops
module tb_sixteen_bit_serial_borrow_select_subtractor;
  localparam int SLICE = 4;
  localparam int LAT = 16 / SLICE;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, Bin = 0;
  logic [15:0] A = 0, B = 0;
  logic in_ready, out_valid, Bout, V;
  logic [15:0] D;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        bin;
    logic [15:0] d;
    logic        bout, v;
  } vec_t;
  vec_t vecs[10];

  sixteen_bit_serial_borrow_select_subtractor #(.SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input int stall, input logic noisy,
                       output logic [15:0] d, output logic bo, output logic v, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_wait", {31'b0, in_ready}, 1);
    A = a; B = b; Bin = bin; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    d = D; bo = Bout; v = V;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (noisy) begin in_valid = 1'($urandom); A = 16'($urandom); B = 16'($urandom); end
      @(posedge clk); #1;
      chk("hold_D", {16'b0, D}, {16'b0, d});
      chk("hold_flags", {30'b0, Bout, V}, {30'b0, bo, v});
      chk("hold_valid", {30'b0, out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    chk("pre_handoff_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    out_ready = 0;
    chk("post_handoff", {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  task automatic check_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic bin, input logic [15:0] ed, input logic eb,
                           input logic ev, input int stall, input logic noisy);
    logic [15:0] d;
    logic bo, v;
    int lat;
    do_op(a, b, bin, stall, noisy, d, bo, v, lat);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_D"}, {16'b0, d}, {16'b0, ed});
    chk({tag, "_Bout"}, {31'b0, bo}, {31'b0, eb});
    chk({tag, "_V"}, {31'b0, v}, {31'b0, ev});
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic rbin;
    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
    #12;
    chk("reset_outputs", {12'b0, D, out_valid, in_ready, Bout, V}, {28'b0, 4'b0100});
    rst_n = 1;
    for (int i = 0; i < 10; i++) check_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
      vecs[i].bin, vecs[i].d, vecs[i].bout, vecs[i].v, 0, 0);
    check_vec("backpressure", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 5, 1);
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; Bin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 0; #1;
    chk("midrun_reset", {14'b0, D, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    chk("reset_held", {14'b0, D, out_valid, in_ready}, 32'b01);
    rst_n = 1;
    check_vec("after_reset", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      full = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
      check_vec("rand", ra, rb, rbin, full[15:0], full[16],
        (ra[15] ^ rb[15]) & (full[15] ^ ra[15]), int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
